// File: rtl/counter_io_core.sv
// Debounced up/down/clear buttons plus prescaled auto-count driving a WIDTH-bit counter.
// Exposes count[12:0] on the IO pads and raises wrap, compare-match and button-event pulses.
module counter_io_core #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_ni,
    input  logic [127:0] la_data_in,
    input  logic [15:0]  io_in,
    output logic [15:0]  io_out,
    output logic [15:0]  io_oeb,
    output logic [2:0]   irq
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    localparam logic [8:0] DB_LIMIT = 9'(DEBOUNCE_CYCLES);

    // Returns {wrap, next}: a modulo-2^WIDTH step of one in either direction.
    function automatic logic [WIDTH:0] step_wrap(input logic [WIDTH-1:0] v, input logic up);
        logic [WIDTH-1:0] nxt;
        logic             wrap;
        if (up) begin
            nxt  = v + WIDTH'(1);
            wrap = &v;
        end else begin
            nxt  = v - WIDTH'(1);
            wrap = (v == '0);
        end
        return {wrap, nxt};
    endfunction

    logic [2:0]       r_sync_p0, r_sync_p1;
    db_state_t        r_db_state [3];
    db_state_t        w_db_state_nxt [3];
    logic [7:0]       r_db_cnt [3];
    logic [7:0]       w_db_cnt_nxt [3];
    logic [2:0]       r_press, w_press_nxt;
    logic [7:0]       r_pre;
    logic             w_tick;
    logic             r_ld_prev, w_load_edge;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [WIDTH:0]   w_step;
    logic             w_wrap, w_eq;
    logic             r_wrap_p0, r_btn_p0, r_eq_hist;
    logic [15:0]      r_io_out;
    logic [2:0]       r_irq;
    logic             w_unused;

    assign w_unused = ^{la_data_in[127:64], la_data_in[47:32], la_data_in[23:19], io_in[15:3]};

    // Debounce next-state: a level must stay changed for DEBOUNCE_CYCLES samples to be accepted.
    always_comb begin
        for (int b = 0; b < 3; b++) begin
            w_db_state_nxt[b] = r_db_state[b];
            w_db_cnt_nxt[b]   = r_db_cnt[b];
            w_press_nxt[b]    = 1'b0;
            case (r_db_state[b])
                RELEASED: begin
                    if (r_sync_p1[b]) begin
                        w_db_state_nxt[b] = PRESS_WAIT;
                        w_db_cnt_nxt[b]   = 8'd1;
                    end
                end
                PRESS_WAIT: begin
                    if (!r_sync_p1[b]) begin
                        w_db_state_nxt[b] = RELEASED;
                        w_db_cnt_nxt[b]   = 8'd0;
                    end else if ({1'b0, r_db_cnt[b]} + 9'd1 >= DB_LIMIT) begin
                        w_db_state_nxt[b] = PRESSED;
                        w_db_cnt_nxt[b]   = 8'd0;
                        w_press_nxt[b]    = 1'b1;
                    end else begin
                        w_db_cnt_nxt[b] = r_db_cnt[b] + 8'd1;
                    end
                end
                PRESSED: begin
                    if (!r_sync_p1[b]) begin
                        w_db_state_nxt[b] = RELEASE_WAIT;
                        w_db_cnt_nxt[b]   = 8'd1;
                    end
                end
                RELEASE_WAIT: begin
                    if (r_sync_p1[b]) begin
                        w_db_state_nxt[b] = PRESSED;
                        w_db_cnt_nxt[b]   = 8'd0;
                    end else if ({1'b0, r_db_cnt[b]} + 9'd1 >= DB_LIMIT) begin
                        w_db_state_nxt[b] = RELEASED;
                        w_db_cnt_nxt[b]   = 8'd0;
                    end else begin
                        w_db_cnt_nxt[b] = r_db_cnt[b] + 8'd1;
                    end
                end
                default: begin
                    w_db_state_nxt[b] = RELEASED;
                    w_db_cnt_nxt[b]   = 8'd0;
                end
            endcase
        end
    end

    // Prescaler uses >= so a P lowered mid-run still ticks promptly instead of rolling over.
    assign w_tick      = la_data_in[17] && (r_pre >= la_data_in[31:24]);
    assign w_load_edge = la_data_in[16] & ~r_ld_prev;
    assign w_eq        = (r_count == WIDTH'(la_data_in[63:48]));

    // Counter action: clear, then load, then tick, then button steps.
    always_comb begin
        w_count_nxt = r_count;
        w_wrap      = 1'b0;
        w_step      = '0;
        if (r_press[2]) begin
            w_count_nxt = '0;
        end else if (w_load_edge) begin
            w_count_nxt = WIDTH'(la_data_in[15:0]);
        end else if (w_tick) begin
            w_step      = step_wrap(r_count, la_data_in[18]);
            w_count_nxt = w_step[WIDTH-1:0];
            w_wrap      = w_step[WIDTH];
        end else if (r_press[0] ^ r_press[1]) begin
            w_step      = step_wrap(r_count, r_press[0]);
            w_count_nxt = w_step[WIDTH-1:0];
            w_wrap      = w_step[WIDTH];
        end
    end

    // p0: synchronizers, debounce, prescaler, counter; p1: interrupt pulses.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
            for (int b = 0; b < 3; b++) begin
                r_db_state[b] <= RELEASED;
                r_db_cnt[b]   <= '0;
            end
            r_press   <= '0;
            r_pre     <= '0;
            r_ld_prev <= 1'b0;
            r_count   <= '0;
            r_io_out  <= '0;
            r_wrap_p0 <= 1'b0;
            r_btn_p0  <= 1'b0;
            r_eq_hist <= 1'b0;
            r_irq     <= '0;
        end else begin
            r_sync_p0 <= io_in[2:0];
            r_sync_p1 <= r_sync_p0;
            for (int b = 0; b < 3; b++) begin
                r_db_state[b] <= w_db_state_nxt[b];
                r_db_cnt[b]   <= w_db_cnt_nxt[b];
            end
            r_press <= w_press_nxt;
            if (!la_data_in[17] || w_tick) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + 8'd1;
            end
            r_ld_prev <= la_data_in[16];
            r_count   <= w_count_nxt;
            r_io_out  <= {13'(w_count_nxt), 3'b000};
            r_wrap_p0 <= w_wrap;
            r_btn_p0  <= |r_press;
            r_eq_hist <= w_eq;
            r_irq     <= {r_btn_p0, w_eq & ~r_eq_hist, r_wrap_p0};
        end
    end

    assign io_out = r_io_out;
    assign irq    = r_irq;
    assign io_oeb = 16'h0007;

endmodule

// File: tb/tb_counter_io_core.sv
// Scoreboarded bench for counter_io_core: directed scenarios followed by random traffic
// against a run-length debounce / modular-arithmetic reference model.
module tb_counter_io_core;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] la;
    logic [15:0]  io_in;
    logic [15:0]  io_out;
    logic [15:0]  io_oeb;
    logic [2:0]   irq;

    always #5 clk = ~clk;

    counter_io_core #(.WIDTH(16), .DEBOUNCE_CYCLES(D)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .la_data_in (la),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_oeb     (io_oeb),
        .irq        (irq)
    );

    typedef struct packed {
        logic [15:0] exp_out;
        logic [2:0]  exp_irq;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    bit [15:0] m_count;
    bit [2:0]  m_s1, m_s2, m_acc, m_press, m_irq;
    int        m_run [3];
    bit        m_wrap_d, m_btn_d, m_eqh, m_ld_prev;
    int        m_en_k;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        m_count = 0; m_s1 = 0; m_s2 = 0; m_acc = 0; m_press = 0; m_irq = 0;
        for (int b = 0; b < 3; b++) m_run[b] = 0;
        m_wrap_d = 0; m_btn_d = 0; m_eqh = 0; m_ld_prev = 0; m_en_k = 0;
    endfunction

    // One rising edge of behaviour given the inputs present at that edge.
    function automatic void model_step(input logic [15:0] in, input logic [127:0] l);
        bit [15:0] cmp;
        int        p;
        bit        tick, ld, wrap, eq_now;
        bit [2:0]  lvl;
        cmp = l[63:48];
        p   = int'(l[31:24]);
        eq_now   = (m_count == cmp);
        m_irq[0] = m_wrap_d;
        m_irq[2] = m_btn_d;
        m_irq[1] = eq_now && !m_eqh;
        m_eqh    = eq_now;
        tick   = l[17] && ((m_en_k % (p + 1)) == p);
        m_en_k = l[17] ? m_en_k + 1 : 0;
        ld        = l[16] && !m_ld_prev;
        m_ld_prev = l[16];
        wrap    = 0;
        m_btn_d = |m_press;
        if (m_press[2]) m_count = 0;
        else if (ld) m_count = l[15:0];
        else if (tick) begin
            if (l[18]) begin wrap = (m_count == 16'hFFFF); m_count = m_count + 1; end
            else begin wrap = (m_count == 0); m_count = m_count - 1; end
        end else if (m_press[0] != m_press[1]) begin
            if (m_press[0]) begin wrap = (m_count == 16'hFFFF); m_count = m_count + 1; end
            else begin wrap = (m_count == 0); m_count = m_count - 1; end
        end
        m_wrap_d = wrap;
        lvl  = m_s2;
        m_s2 = m_s1;
        m_s1 = in[2:0];
        m_press = 0;
        for (int b = 0; b < 3; b++) begin
            if (lvl[b] != m_acc[b]) begin
                m_run[b]++;
                if (m_run[b] == D) begin
                    m_acc[b]   = lvl[b];
                    m_run[b]   = 0;
                    m_press[b] = lvl[b];
                end
            end else begin
                m_run[b] = 0;
            end
        end
    endfunction

    function automatic logic [127:0] mk(input logic [15:0] ldv, input logic ldr, input logic en,
                                        input logic dir, input logic [7:0] p, input logic [15:0] cmp);
        logic [127:0] l;
        l = '0;
        l[15:0] = ldv; l[16] = ldr; l[17] = en; l[18] = dir; l[31:24] = p; l[63:48] = cmp;
        return l;
    endfunction

    task automatic drive(input logic [15:0] in, input logic [127:0] l);
        exp_t e;
        io_in = in;
        la    = l;
        model_step(in, l);
        e.exp_out = {m_count[12:0], 3'b000};
        e.exp_irq = m_irq;
        sbq.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares every presented output cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sb_io_out", 32'(io_out), 32'(e.exp_out));
                chk("sb_irq", 32'(irq), 32'(e.exp_irq));
                chk("sb_io_oeb", 32'(io_oeb), 32'h0007);
            end
        end
    end

    initial begin
        logic [127:0] l0, l;
        logic [15:0]  rin;
        bit           en, dir, ldr;
        int           p, pulses;
        bit [15:0]    cmp, ldv;

        l0    = mk(16'h0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h7777);
        rst_n = 1'b0;
        io_in = '0;
        la    = l0;
        model_reset();
        #3;
        chk("reset_io_out", 32'(io_out), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_io_oeb", 32'(io_oeb), 32'h0007);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Held up button: count moves exactly D+3 edges later, irq[2] one edge after that.
        for (int e = 1; e <= 10; e++) begin
            drive(16'h0001, l0);
            if (e == 6) chk("hold_e6_out", 32'(io_out), 32'h0);
            if (e == 7) begin
                chk("hold_e7_out", 32'(io_out), 32'h8);
                chk("hold_e7_irq", 32'(irq), 32'h0);
            end
            if (e == 8) chk("hold_e8_irq", 32'(irq), 32'h4);
            if (e == 10) chk("hold_e10_out", 32'(io_out), 32'h8);
        end
        for (int e = 0; e < 10; e++) drive(16'h0, l0);

        // Three-cycle glitch is rejected.
        for (int e = 0; e < 3; e++) drive(16'h0001, l0);
        pulses = 0;
        for (int e = 0; e < 10; e++) begin
            drive(16'h0, l0);
            if (irq != 3'b000) pulses++;
        end
        chk("glitch_irq_cycles", 32'(pulses), 32'h0);
        chk("glitch_out", 32'(io_out), 32'h8);

        // Load FFFE and auto-count up: wrap to 0 and a single irq[0].
        drive(16'h0, mk(16'hFFFE, 1'b1, 1'b1, 1'b1, 8'd0, 16'h7777));
        chk("load_fffe_out", 32'(io_out), 32'hFFF0);
        pulses = 0;
        for (int e = 1; e <= 5; e++) begin
            drive(16'h0, mk(16'hFFFE, 1'b0, 1'b1, 1'b1, 8'd0, 16'h7777));
            if (e == 1) chk("up_ffff_out", 32'(io_out), 32'hFFF8);
            if (e == 2) chk("wrap_zero_out", 32'(io_out), 32'h0);
            if (e == 3) chk("wrap_irq0", 32'(irq[0]), 32'h1);
            if (irq[0]) pulses++;
        end
        chk("wrap_irq0_count", 32'(pulses), 32'h1);
        drive(16'h0, l0);

        // P=3 down-count from 5 with compare value 2.
        drive(16'h0, mk(16'd5, 1'b1, 1'b1, 1'b0, 8'd3, 16'd2));
        pulses = 0;
        for (int e = 1; e <= 17; e++) begin
            drive(16'h0, mk(16'd5, 1'b0, 1'b1, 1'b0, 8'd3, 16'd2));
            if (e == 2) chk("pre_e2_out", 32'(io_out), 32'(16'd5 << 3));
            if (e == 3) chk("pre_e3_out", 32'(io_out), 32'(16'd4 << 3));
            if (e == 7) chk("pre_e7_out", 32'(io_out), 32'(16'd3 << 3));
            if (e == 11) chk("pre_e11_out", 32'(io_out), 32'(16'd2 << 3));
            if (e == 12) chk("cmp_irq1", 32'(irq[1]), 32'h1);
            if (irq[1]) pulses++;
        end
        chk("cmp_irq1_count", 32'(pulses), 32'h1);
        drive(16'h0, l0);

        // Clear press and load edge in the same cycle: clear wins; a later edge loads.
        for (int e = 1; e <= 6; e++) drive(16'h0004, mk(16'h0ABC, 1'b0, 1'b0, 1'b0, 8'd0, 16'h7777));
        chk("pre_clear_out", 32'(io_out), 32'h8);
        drive(16'h0004, mk(16'h0ABC, 1'b1, 1'b0, 1'b0, 8'd0, 16'h7777));
        chk("clear_beats_load", 32'(io_out), 32'h0);
        for (int e = 0; e < 10; e++) drive(16'h0, mk(16'h0ABC, 1'b1, 1'b0, 1'b0, 8'd0, 16'h7777));
        chk("held_load_no_reload", 32'(io_out), 32'h0);
        drive(16'h0, mk(16'h0ABC, 1'b0, 1'b0, 1'b0, 8'd0, 16'h7777));
        drive(16'h0, mk(16'h0ABC, 1'b1, 1'b0, 1'b0, 8'd0, 16'h7777));
        chk("second_load_out", 32'(io_out), 32'h55E0);

        // Half-cycle reset mid-PRESS_WAIT discards debounce progress.
        drive(16'h0, mk(16'h0100, 1'b0, 1'b0, 1'b0, 8'd0, 16'h7777));
        drive(16'h0, mk(16'h0100, 1'b1, 1'b0, 1'b0, 8'd0, 16'h7777));
        chk("preload_out", 32'(io_out), 32'h0800);
        for (int e = 0; e < 4; e++) drive(16'h0001, mk(16'h0100, 1'b0, 1'b0, 1'b0, 8'd0, 16'h7777));
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("midreset_out", 32'(io_out), 32'h0);
        chk("midreset_irq", 32'(irq), 32'h0);
        chk("midreset_oeb", 32'(io_oeb), 32'h0007);
        #3;
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            drive(16'h0001, mk(16'h0100, 1'b0, 1'b0, 1'b0, 8'd0, 16'h7777));
            if (e == 6) chk("rst_hold_e6_out", 32'(io_out), 32'h0);
            if (e == 7) chk("rst_hold_e7_out", 32'(io_out), 32'h8);
            if (e == 8) chk("rst_hold_e8_irq", 32'(irq), 32'h4);
        end
        for (int e = 0; e < 10; e++) drive(16'h0, l0);

        // Random traffic against the model.
        rin = 0; en = 0; dir = 1; ldr = 0; p = 0; cmp = 16'h7777; ldv = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 3; b++) if ($urandom_range(0, 9) == 0) rin[b] = ~rin[b];
            rin[15:3] = 13'($urandom());
            if ($urandom_range(0, 15) == 0) ldr = ~ldr;
            if ($urandom_range(0, 7) == 0) ldv = 16'($urandom());
            if ($urandom_range(0, 29) == 0) en = ~en;
            if (!en && $urandom_range(0, 3) == 0) p = $urandom_range(0, 3);
            if ($urandom_range(0, 39) == 0) dir = ~dir;
            if ($urandom_range(0, 19) == 0) cmp = m_count + 16'($urandom_range(0, 3));
            l = {$urandom(), $urandom(), $urandom(), $urandom()};
            l[15:0] = ldv; l[16] = ldr; l[17] = en; l[18] = dir;
            l[31:24] = 8'(p); l[63:48] = cmp;
            drive(rin, l);
        end

        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/counter_io_core.md
COUNTER_IO_CORE -- requirements
Module: counter_io_core

Interface
REQ-001 SHALL have parameter WIDTH, default 16: counter width in bits.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed to accept a button level; legal range 1..255.
REQ-003 SHALL have port wb_clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port wb_rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port la_data_in, input, 128 bits, with these fields:
- [15:0] load value.
- [16] load request; its rising edge loads the counter.
- [17] auto-count enable.
- [18] direction: 1 = up, 0 = down.
- [31:24] prescale P.
- [63:48] compare value.
- all other bits ignored.
REQ-006 SHALL have port io_in, input, 16 bits: [0] up button, [1] down button, [2] clear button, all active-high; [15:3] ignored.
REQ-007 SHALL have port io_out, output, 16 bits: [2:0] driven 0; [15:3] = count[12:0].
REQ-008 SHALL have port io_oeb, output, 16 bits: constant 16'h0007, i.e. [2:0] are inputs and [15:3] are outputs.
REQ-009 SHALL have port irq, output, 3 bits: [0] wrap, [1] compare match, [2] button event; each a registered one-cycle pulse.

Function
REQ-010 SHALL pass io_in[2:0] through a 2-flop synchronizer before any use.
REQ-011 SHALL run one debounce FSM per button with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT:
- RELEASED -> PRESS_WAIT when the synced level is 1; stable-count set to 1.
- PRESS_WAIT: synced level 0 -> RELEASED; otherwise stable-count increments; on reaching DEBOUNCE_CYCLES -> PRESSED and emit a one-cycle press pulse.
- PRESSED -> RELEASE_WAIT when the synced level is 0.
- RELEASE_WAIT: mirror of PRESS_WAIT back to RELEASED; no pulse is emitted on release.
REQ-012 The counter SHALL update DEBOUNCE_CYCLES+3 rising edges after io_in[0] or io_in[1] goes high and is held stable.
REQ-013 The prescaler SHALL emit a tick every P+1 cycles while la_data_in[17]=1:
- P=0 gives a tick every cycle.
- The prescaler SHALL clear to 0 while la_data_in[17]=0.
REQ-014 The counter SHALL be updated once per cycle with fixed priority:
- 1. clear press pulse -> 0.
- 2. load-request rising edge -> la_data_in[15:0] truncated or zero-extended to WIDTH.
- 3. prescaler tick -> count ±1 per la_data_in[18].
- 4. up press pulse -> +1; down press pulse -> -1.
- Up and down pulses in the same cycle cancel (no change).
- Only the highest-priority action applies; lower-priority events in that cycle are dropped.
REQ-015 Arithmetic SHALL wrap modulo 2^WIDTH.
REQ-016 irq[0] SHALL pulse in the cycle after an increment from all-ones to 0, or a decrement from 0 to all-ones; loads and clears SHALL NOT assert it.
REQ-017 irq[1] SHALL pulse in the cycle after count becomes equal to the compare value from a different value, whatever the cause (load, clear, count); staying equal SHALL NOT re-pulse.
REQ-018 irq[2] SHALL pulse in the cycle after any press pulse (up, down or clear); simultaneous presses produce a single pulse.
REQ-019 The load-request edge detector SHALL register la_data_in[16] every cycle; holding the bit high SHALL NOT cause repeated loads.
REQ-020 io_out and irq SHALL be driven directly from flops, with no combinational path from inputs.

Reset
REQ-021 While wb_rst_ni=0, the following SHALL hold immediately, without needing a clock edge:
- count = 0, irq = 0, io_out = 0.
- synchronizers = 0, debounce FSMs = RELEASED with stable-count 0.
- prescaler = 0, load-edge register = 0, compare-equal history = 0.
REQ-022 Reset asserted mid-debounce or mid-prescale SHALL discard all partial progress; after release, counting restarts from zero state.
REQ-023 Reset deassertion SHALL take effect at the next rising edge; io_oeb SHALL stay 16'h0007 during and after reset.

Verification
REQ-024 DEBOUNCE_CYCLES=4: io_in[0] high and held -> count 0 -> 1 exactly 7 edges later, irq[2] pulses one cycle later, and no further change while held.
REQ-025 io_in[0] glitch of 3 cycles with DEBOUNCE_CYCLES=4 -> count unchanged, irq stays 0.
REQ-026 Load 16'hFFFE, auto-count up with P=0 -> count FFFF, then 0000; irq[0] pulses once, one cycle after the wrap.
REQ-027 P=3, down, start value 5 -> count decrements once every 4 cycles: 4, 3, 2, ...; compare value 2 -> irq[1] pulses once.
REQ-028 Clear press and load edge in the same cycle -> count = 0; a second load edge later loads la_data_in[15:0].
REQ-029 wb_rst_ni pulsed low for half a cycle mid-PRESS_WAIT -> all outputs 0 at once, and the held button needs a full DEBOUNCE_CYCLES+3 edges again after release.
